// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared client/bank address map constants and helpers
package mem_pkg;
  localparam int N_CLIENTS  = 16;
  localparam int LINE_W     = 256;
  localparam int ADDR_W     = 19;
  localparam int BANK_W     = 4;
  localparam int LINE_IDX_W = 10;

  // Banks interleave on 32-byte lines within each 64 KiB region.
  function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
    return {addr[18:16], addr[5]};
  endfunction

  function automatic logic [LINE_IDX_W-1:0] line_of(input logic [ADDR_W-1:0] addr);
    return addr[15:6];
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
  parameter int N = 16,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any_gnt
);
  always_comb begin
    gnt     = '0;
    idx     = '0;
    any_gnt = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any_gnt && req[(int'(ptr) + i) % N]) begin
        any_gnt = 1'b1;
        idx     = IW'((int'(ptr) + i) % N);
      end
    end
    if (any_gnt) gnt[idx] = 1'b1;
  end
endmodule

// File: rtl/mem_bank_arb.sv
// rtl/mem_bank_arb.sv - one SRAM bank: round-robin client grant, SRAM drive, read return
module mem_bank_arb #(
  parameter int N_CLIENTS = mem_pkg::N_CLIENTS,
  parameter int LINE_W    = mem_pkg::LINE_W,
  parameter int ADDR_W    = mem_pkg::ADDR_W,
  parameter int BANK_ID   = 0,
  parameter int RD_LAT    = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_CLIENTS-1:0]                req,
  input  logic [N_CLIENTS-1:0]                req_we,
  input  logic [N_CLIENTS-1:0][ADDR_W-1:0]    req_addr,
  input  logic [N_CLIENTS-1:0][LINE_W-1:0]    req_wdata,
  input  logic [N_CLIENTS-1:0][LINE_W-1:0]    req_mask,
  output logic [N_CLIENTS-1:0]                gnt,
  output logic                                sram_ce,
  output logic                                sram_we,
  output logic [9:0]                          sram_addr,
  output logic [LINE_W-1:0]                   sram_wdata,
  output logic [LINE_W-1:0]                   sram_wmask,
  input  logic [LINE_W-1:0]                   sram_rdata,
  output logic [N_CLIENTS-1:0]                rvalid,
  output logic [LINE_W-1:0]                   rdata,
  output logic                                err_bank
);
  import mem_pkg::*;

  localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  logic [IW-1:0]              rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]              gnt_idx;
  logic                       any_gnt;
  logic [RD_LAT-1:0]          pipe_v_q, pipe_v_d;
  logic [RD_LAT-1:0][IW-1:0]  pipe_id_q, pipe_id_d;
  logic [N_CLIENTS-1:0]       rvalid_q, rvalid_d;
  logic [LINE_W-1:0]          rdata_q, rdata_d;
  logic                       err_bank_q, err_bank_d;

  rr_arbiter #(.N(N_CLIENTS)) u_arb (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .idx     (gnt_idx),
    .any_gnt (any_gnt)
  );

  always_comb begin
    sram_ce    = any_gnt;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_wmask = '0;
    if (any_gnt) begin
      sram_we    = req_we[gnt_idx];
      sram_addr  = line_of(req_addr[gnt_idx]);
      sram_wdata = req_wdata[gnt_idx];
      sram_wmask = req_mask[gnt_idx];
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_gnt) begin
      rr_ptr_d = (int'(gnt_idx) == N_CLIENTS - 1) ? '0 : gnt_idx + IW'(1);
    end

    // Reads enter stage 0 in their grant cycle; the last stage lines up with sram_rdata.
    pipe_v_d[0]  = any_gnt && !req_we[gnt_idx];
    pipe_id_d[0] = gnt_idx;
    for (int s = 1; s < RD_LAT; s++) begin
      pipe_v_d[s]  = pipe_v_q[s-1];
      pipe_id_d[s] = pipe_id_q[s-1];
    end

    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (pipe_v_q[RD_LAT-1]) begin
      rvalid_d[pipe_id_q[RD_LAT-1]] = 1'b1;
      rdata_d                       = sram_rdata;
    end

    err_bank_d = err_bank_q ||
                 (any_gnt && (bank_of(req_addr[gnt_idx]) != BANK_W'(BANK_ID)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      pipe_v_q   <= '0;
      pipe_id_q  <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      err_bank_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      pipe_v_q   <= pipe_v_d;
      pipe_id_q  <= pipe_id_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      err_bank_q <= err_bank_d;
    end
  end

  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign err_bank = err_bank_q;
endmodule

// File: doc/mem_bank_arb.md
Name: mem_bank_arb

Overview:
- SRAM-bank side of the client-to-memory request fabric; one instance per SRAM bank (16 banks total).
- Receives per-client line requests from the client-side request controller, which raises `req[client][bank]` and holds it until granted.
- Grants one client per cycle under round-robin fairness and drives the bank's SRAM port.
- Returns read data to the granted client after a fixed latency.
- Bank select is {addr[18:16], addr[5]}; line index within the bank is addr[15:6] (1024 lines × 32 bytes).

Parameters:
- N_CLIENTS, 16, number of requesting clients.
- LINE_W, 256, SRAM line width in bits.
- ADDR_W, 19, client byte-address width.
- BANK_ID, 0, this instance's bank number (0..15), compared against {addr[18:16], addr[5]}.
- RD_LAT, 1, SRAM read latency in cycles from sram_ce to valid sram_rdata (1..4).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_CLIENTS  per-client request to this bank; held until gnt.
- req_we  in  N_CLIENTS  1 = write, 0 = read.
- req_addr  in  N_CLIENTS×ADDR_W  client byte address.
- req_wdata  in  N_CLIENTS×LINE_W  write line data.
- req_mask  in  N_CLIENTS×LINE_W  bit write-enable; 1 = write this bit.
- gnt  out  N_CLIENTS  one-hot grant, same cycle as the accepted req.
- sram_ce  out  1  SRAM access strobe.
- sram_we  out  1  SRAM write.
- sram_addr  out  10  line index = req_addr[15:6] of the granted client.
- sram_wdata  out  LINE_W  granted client's req_wdata.
- sram_wmask  out  LINE_W  granted client's req_mask.
- sram_rdata  in  LINE_W  SRAM read data, valid RD_LAT cycles after a read strobe.
- rvalid  out  N_CLIENTS  one-hot; read data for that client on rdata this cycle.
- rdata  out  LINE_W  registered read data, shared by all clients.
- err_bank  out  1  sticky; set when any granted request's bank bits ≠ BANK_ID.

Behaviour:
- Reset (async, rst_n=0):
  - rr_ptr=0, read pipeline cleared, rvalid=0, rdata=0, err_bank=0.
  - gnt and the sram_* outputs follow the combinational rules below; with req=0 they are 0.
- Arbitration (combinational):
  - Search req starting at index rr_ptr, upward with wrap modulo N_CLIENTS.
  - The first set bit k gets gnt[k]=1; at most one gnt bit is set.
  - No req means gnt=0.
- Pointer update: on any grant to k, rr_ptr <= (k+1) mod N_CLIENTS at the next edge; with no grant, rr_ptr holds.
- SRAM drive (combinational, grant cycle t):
  - sram_ce=|gnt, sram_we=req_we[k].
  - sram_addr, sram_wdata and sram_wmask are muxed from client k.
  - With no grant, all sram_* = 0.
- Read return:
  - A shift register of depth RD_LAT carries {valid, client_id}; a read granted at t enters at t.
  - At t+RD_LAT, sram_rdata is captured into rdata, and rvalid[client_id] is asserted in cycle t+RD_LAT+1 for exactly 1 cycle.
  - Total grant-to-rvalid latency is RD_LAT+1.
  - Fully pipelined: back-to-back reads (any clients) return in grant order, one per cycle.
- rdata holds its last value when rvalid=0. Writes produce no rvalid.
- Write then read of the same line in consecutive cycles: the read returns the new data. The SRAM is write-first, with no bypass in this block.
- A client asserting req at t and granted at t may drop or change req at t+1; the block holds no request state beyond the read pipeline.
- err_bank: set at the edge after a granted request whose {addr[18:16], addr[5]} ≠ BANK_ID. The access is still performed (no deadlock). Cleared only by reset.
- Reset mid-operation: in-flight reads are discarded and no rvalid is produced for them after reset release.
- Throughput: 1 access per cycle; worst-case wait for any continuously requesting client is N_CLIENTS-1 cycles.

Decomposition:
- Package mem_pkg:
  - N_CLIENTS, LINE_W, ADDR_W, BANK_W=4, LINE_IDX_W=10.
  - Function bank_of(addr) returning {addr[18:16], addr[5]}.
  - Function line_of(addr) returning addr[15:6].
  - Shared by this block and the client-side request controller.
- Sub-module rr_arbiter (N parameter):
  - Inputs: req, ptr. Outputs: one-hot gnt, grant index, any_gnt.
  - Purely combinational; the pointer register stays in mem_bank_arb.

Test Plan:
- Single read: BANK_ID=3, RD_LAT=1, client 5 reads addr 0x10020, sram_rdata=0xA5…A5 → gnt[5] same cycle, sram_addr=0x000, sram_we=0; rvalid[5]=1 two cycles later with rdata=0xA5…A5; err_bank=0.
- Masked write: client 2 writes addr 0x000C0 (bank 0, line 3), mask low 128 bits set → sram_we=1, sram_addr=3, sram_wmask matches; no rvalid ever.
- Contention fairness: all 16 clients hold req for 32 cycles, rr_ptr=0 at start → grants in order 0,1,…,15,0,…,15; each client granted exactly twice.
- Pipelined reads, RD_LAT=3: clients 1, 7, 12 read in consecutive cycles → rvalid[1], rvalid[7], rvalid[12] on consecutive cycles starting 4 cycles after the first grant, data in order.
- Reset mid-read: grant a read, assert rst_n=0 the next cycle, release → rvalid stays 0 throughout; rr_ptr=0 (client 0 wins a full contention).
- Bank mismatch: BANK_ID=0, client 9 reads addr 0x00020 (bank 1) → access performed with rvalid[9] as normal; err_bank=1 from the next cycle until reset.
